// File: rtl/debug_read_arbiter.sv
// debug_read_arbiter: round-robin sharing of one registered read-only debug slave among NUM_REQ Avalon-MM read masters.
module debug_read_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 32,
  parameter int SLAVE_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]           s_address,
  input  logic [DATA_W-1:0]           s_readdata
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, WAIT, RETURN} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       last_q, last_d, grant_q, grant_d, win, idx;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  rdv_q, rdv_d;
  logic                found;
  // search begins just after the last winner so every master gets a turn
  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_read[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    rdata_d         = rdata_q;
    rdv_d           = '0;
    req_waitrequest = '1;
    case (state_q)
      IDLE: if (found) begin
        req_waitrequest[win] = 1'b0;
        addr_d  = req_address[win*ADDR_W +: ADDR_W];
        grant_d = win;
        last_d  = win;
        cnt_d   = 3'(SLAVE_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RETURN : WAIT;
      end
      RETURN: begin
        rdata_d        = s_readdata;
        rdv_d[grant_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      rdv_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end
  assign s_address         = addr_q;
  assign req_readdata      = rdata_q;
  assign req_readdatavalid = rdv_q;
endmodule

// File: tb/tb_debug_read_arbiter.sv
// tb_debug_read_arbiter: directed bench for two arbiter instances (slave latency 1 and 3) against a cycle-timing model.
module tb_debug_read_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_read;
  logic [7:0]  req_address;
  logic [7:0]  salt;
  logic [3:0]  wr1, wr3, rdv1, rdv3;
  logic [31:0] rdata1, rdata3, srd1, srd3;
  logic [1:0]  saddr1, saddr3;
  int          cyc = -1;
  int          n_err = 0, n_chk = 0;
  int          m_last[2], m_free[2], m_pulse[2], m_pg[2];
  logic [31:0] m_rdata[2], m_sprev[2];
  logic [1:0]  m_addr[2];
  int          win, lat;
  logic [3:0]  e_wr, e_rdv;
  int          acc_q[$], cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) srd1 <= {16'hA5A5, salt, 6'd0, saddr1};
  always @(posedge clk) srd3 <= {16'hA5A5, salt, 6'd0, saddr3};

  debug_read_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32), .SLAVE_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_read(req_read), .req_address(req_address),
    .req_waitrequest(wr1), .req_readdata(rdata1), .req_readdatavalid(rdv1),
    .s_address(saddr1), .s_readdata(srd1));
  debug_read_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(32), .SLAVE_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_read(req_read), .req_address(req_address),
    .req_waitrequest(wr3), .req_readdata(rdata3), .req_readdatavalid(rdv3),
    .s_address(saddr3), .s_readdata(srd3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model view: an instance is free from the pulse cycle of its last read, and the
  // pulse of a read accepted at cycle c lands at c+L+2 carrying the slave word of c+L+1.
  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      lat = (u == 0) ? 1 : 3;
      win = -1;
      if (cyc >= m_free[u] && req_read != 4'd0)
        for (int k = 1; k <= 4; k++)
          if (win < 0 && req_read[(m_last[u] + k) % 4]) win = (m_last[u] + k) % 4;
      e_wr = 4'hF;
      if (win >= 0) e_wr[win] = 1'b0;
      e_rdv = 4'd0;
      if (m_pulse[u] == cyc) begin
        e_rdv[m_pg[u]] = 1'b1;
        m_rdata[u] = m_sprev[u];
      end
      chk($sformatf("L%0d_waitrequest", lat), {28'd0, (u == 0) ? wr1 : wr3}, {28'd0, e_wr});
      chk($sformatf("L%0d_readdatavalid", lat), {28'd0, (u == 0) ? rdv1 : rdv3}, {28'd0, e_rdv});
      chk($sformatf("L%0d_readdata", lat), (u == 0) ? rdata1 : rdata3, m_rdata[u]);
      chk($sformatf("L%0d_s_address", lat), {30'd0, (u == 0) ? saddr1 : saddr3}, {30'd0, m_addr[u]});
      if (reset) begin
        m_last[u] = 3; m_free[u] = cyc + 1; m_pulse[u] = -1; m_addr[u] = 2'd0; m_rdata[u] = 32'd0;
      end else if (win >= 0) begin
        m_last[u] = win; m_addr[u] = req_address[win*2 +: 2];
        m_free[u] = cyc + lat + 2; m_pulse[u] = m_free[u]; m_pg[u] = win;
      end
      m_sprev[u] = (u == 0) ? srd1 : srd3;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic serve(input int maxc);
    logic [3:0] acc;
    acc_q.delete();
    cyc_q.delete();
    for (int k = 0; k < maxc && req_read != 4'd0; k++) begin
      #1;
      acc = req_read & ~wr1;
      for (int i = 0; i < 4; i++)
        if (acc[i]) begin
          acc_q.push_back(i);
          cyc_q.push_back(cyc);
        end
      step();
      req_read = req_read & ~acc;
    end
    chk("serve_timeout", {28'd0, req_read}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_read = 4'd0; req_address = 8'd0; salt = 8'd0;
    for (int u = 0; u < 2; u++) begin
      m_last[u] = 3; m_free[u] = 0; m_pulse[u] = -1; m_addr[u] = 2'd0; m_rdata[u] = 32'd0; m_pg[u] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        if (cyc >= 0) model_step();
      end
    join_none
    step();
    #1;
    chk("rst_waitrequest", {28'd0, wr1}, 32'hF);
    chk("rst_readdatavalid", {28'd0, rdv1}, 32'd0);
    chk("rst_readdata", rdata1, 32'd0);
    chk("rst_s_address", {30'd0, saddr1}, 32'd0);
    step();
    reset = 1'b0;
    idle(2);
    // single read: master 2, address 1
    req_address = {2'd3, 2'd1, 2'd2, 2'd0};
    req_read = 4'b0100;
    #1 chk("single_accept", {28'd0, wr1}, 32'b1011);
    step();
    req_read = 4'd0;
    #1 chk("single_s_address", {30'd0, saddr1}, 32'd1);
    idle(2);
    chk("single_rdv", {28'd0, rdv1}, 32'b0100);
    chk("single_data", rdata1, 32'hA5A5_0001);
    idle(2);
    chk("lat3_rdv", {28'd0, rdv3}, 32'b0100);
    chk("lat3_data", rdata3, 32'hA5A5_0001);
    idle(4);
    // contention after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    salt = 8'd1;
    req_address = {2'd3, 2'd2, 2'd1, 2'd0};
    req_read = 4'hF;
    serve(40);
    chk("cont_count", acc_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < acc_q.size()) begin
        chk($sformatf("cont_order%0d", i), acc_q[i], i);
        chk($sformatf("cont_spacing%0d", i), cyc_q[i] - cyc_q[0], 3 * i);
      end
    idle(6);
    // rotation: master 1 served, then 0 and 1 together
    salt = 8'd2;
    req_read = 4'b0010;
    #1 chk("rot_prime", {28'd0, wr1}, 32'b1101);
    step();
    req_read = 4'd0;
    idle(6);
    req_read = 4'b0011;
    serve(20);
    chk("rot_count", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) begin
      chk("rot_first", acc_q[0], 32'd0);
      chk("rot_second", acc_q[1], 32'd1);
    end
    idle(6);
    // back-to-back for master 0
    salt = 8'd3;
    req_read = 4'b0001;
    #1 chk("b2b_accept", {28'd0, wr1}, 32'b1110);
    step();
    req_read = 4'd0;
    idle(2);
    req_read = 4'b0001;
    #1 chk("b2b_rdv1", {28'd0, rdv1}, 32'b0001);
    chk("b2b_reaccept", {28'd0, wr1}, 32'b1110);
    step();
    req_read = 4'd0;
    idle(2);
    chk("b2b_rdv2", {28'd0, rdv1}, 32'b0001);
    chk("b2b_data", rdata1, 32'hA5A5_0300);
    idle(6);
    // reset while in WAIT
    req_read = 4'b1000;
    #1 chk("rst_mid_accept", {28'd0, wr1}, 32'b0111);
    step();
    req_read = 4'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("rst_mid_rdv", {28'd0, rdv1}, 32'd0);
    chk("rst_mid_wr", {28'd0, wr1}, 32'hF);
    chk("rst_mid_s_address", {30'd0, saddr1}, 32'd0);
    chk("rst_mid_data", rdata1, 32'd0);
    step();
    chk("rst_mid_no_pulse", {28'd0, rdv1}, 32'd0);
    salt = 8'd4;
    req_address = {2'd3, 2'd2, 2'd1, 2'd2};
    req_read = 4'b0001;
    #1 chk("rst_mid_regrant", {28'd0, wr1}, 32'b1110);
    step();
    req_read = 4'd0;
    idle(2);
    chk("rst_mid_rdv_after", {28'd0, rdv1}, 32'b0001);
    chk("rst_mid_data_after", rdata1, 32'hA5A5_0402);
    idle(8);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
